variable_delay_responder: RTL and testbench
===========================================

// Module: variable_delay_responder
// PURPOSE
//  Response generator for the variable-delay trigger->response protocol: each trig_i sampled high
//  at edge t causes resp_o to be high for exactly one cycle, sampled at edge t+D.
//  D is a runtime-programmable delay. Up to DEPTH triggers may be outstanding.
//  Serves as the DUT/stimulus side for the a |-> ##D b style checkers in the assertion library.
// PARAMETERS
//  MAX_DELAY      15  largest programmable delay, in cycles
//  DEPTH          16  max outstanding triggers; DEPTH >= MAX_DELAY sustains back-to-back triggers
//  DEFAULT_DELAY   2  active delay after reset
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  trig_i       in   1      trigger; one response is scheduled per accepted high cycle
//  delay_i      in   DW     new delay value; DW = vdr_pkg::DLY_W
//  delay_load   in   1      request to load delay_i into the active delay
//  resp_o       out  1      response pulse
//  busy_o       out  1      one or more responses pending
//  pending_o    out  CW     number of pending responses, 0..DEPTH
//  load_err_o   out  1      1-cycle pulse: delay_load rejected
//  overflow_o   out  1      sticky: a trigger was dropped
// BEHAVIOUR
//  Reset (edge with rst=1):
//   - FIFO flushed; timestamp counter cleared; active delay set to DEFAULT_DELAY.
//   - resp_o, busy_o, pending_o, load_err_o and overflow_o are all 0 from the next cycle.
//   - Pending responses are discarded, including any whose due edge coincides with reset.
//  Timestamp:
//   - now_q is a free-running TS_W-bit counter, TS_W = clog2(MAX_DELAY+1)+1.
//   - It wraps modulo 2^TS_W. Due matching uses equality only, so wrap is transparent.
//  Trigger with D>=1:
//   - On an edge with trig_i=1, the due time (now_q + D) is pushed into the FIFO.
//   - resp_o = busy && (head_due == now_q). It is combinational from registered state only.
//   - When resp_o is high, the head is popped at that edge.
//   - Due times are strictly increasing, so at most one response fires per cycle.
//  Trigger with D=0:
//   - resp_o = trig_i, a combinational bypass. Nothing is pushed.
//   - It cannot collide with a FIFO pop, because the FIFO is empty whenever D can be 0
//     (see Delay load).
//  Full FIFO:
//   - trig_i while full is accepted only if a pop occurs at the same edge
//     (simultaneous push and pop are legal).
//   - Otherwise the trigger is dropped and overflow_o is set until rst.
//  Delay load:
//   - Accepted only when busy_o=0 and trig_i=0.
//   - The new value takes effect for triggers from the next edge.
//   - delay_i > MAX_DELAY is clamped to MAX_DELAY.
//   - If busy_o=1 or trig_i=1, the load is ignored and load_err_o pulses for 1 cycle.
//  pending_o: pushes minus pops. busy_o = (pending_o != 0).
// CONFIGURATION
//  VDR_SVA_EN defined:
//   - Embedded concurrent checks, disabled during rst:
//     (a) each accepted trig_i is followed by resp_o exactly D cycles later;
//     (b) resp_o never fires while nothing is pending (D>=1);
//     (c) overflow_o never falls except on rst.
//   - Failures are reported with $error.
//  VDR_SVA_EN undefined:
//   - No assertion code. Function and ports are identical.
// STRUCTURE
//  vdr_pkg:
//   - DLY_W, TS_W, CW localparams derived from MAX_DELAY and DEPTH.
//   - typedefs delay_t and ts_t.
//   - function clamp_delay().
//  Sub-module vdr_fifo:
//   - Synchronous FIFO of ts_t, DEPTH entries, pointer-based.
//   - Outputs full, empty, count and head.
//   - Supports push and pop at the same edge.
// TESTING
//  1 Reset default D=2; trig_i pulse at edge 1 -> resp_o=1 at edge 3 only; busy_o low after edge 3.
//  2 Load D=5 when idle; trig_i high edges 2..9 -> resp_o high edges 7..14; pending_o peaks at 5.
//  3 Load D=0 -> resp_o mirrors trig_i in the same cycle; busy_o stays 0.
//  4 D=15, DEPTH=4; trig_i high 6 cycles -> 4 responses; overflow_o=1 and held until rst.
//  5 delay_load while busy_o=1 -> load_err_o 1-cycle pulse; old D kept. Load 20 -> D clamps to 15.
//  6 Three triggers pending, rst asserted -> no resp_o afterward; pending_o=0; next trig uses D=2.
//    Also run 300 cycles of random trig_i to cross the now_q wrap.

Source files
------------

// File: rtl/vdr_pkg.sv
// Shared types and sizing for the variable-delay responder.
// Delay inputs are one bit wider than MAX_DELAY needs so that out-of-range requests can be clamped.
package vdr_pkg;

  localparam int MAX_DELAY_DEF     = 15;
  localparam int DEPTH_DEF         = 16;
  localparam int DEFAULT_DELAY_DEF = 2;

  localparam int TS_W  = $clog2(MAX_DELAY_DEF + 1) + 1;
  localparam int DLY_W = TS_W;
  localparam int CW    = $clog2(DEPTH_DEF + 1);

  typedef logic [DLY_W-1:0] delay_t;
  typedef logic [TS_W-1:0]  ts_t;

  function automatic delay_t clamp_delay(input delay_t d, input delay_t max_d);
    delay_t r;
    if (d > max_d) begin
      r = max_d;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/vdr_checker.sv
// Concurrent checks for the responder, compiled only when VDR_SVA_EN is defined.
`ifdef VDR_SVA_EN
module vdr_checker
  import vdr_pkg::*;
(
  input logic          clk,
  input logic          rst,
  input logic          trig_i,
  input logic          push_i,
  input delay_t        dly_i,
  input logic          resp_o,
  input logic [CW-1:0] pending_o,
  input logic          overflow_o
);

  localparam int SW = 1 << DLY_W;

  // Bit p set means a response is owed at the edge p+1 cycles after the current one.
  logic [SW-1:0] sched_q, sched_d;

  always_comb begin
    sched_d = sched_q >> 1;
    if (push_i) begin
      sched_d[dly_i - delay_t'(1)] = 1'b1;
    end else begin
      sched_d = sched_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sched_q <= '0;
    end else begin
      sched_q <= sched_d;
    end
  end

  a_resp_on_time : assert property (@(posedge clk) disable iff (rst)
    (sched_q[0] || (trig_i && dly_i == '0)) |-> resp_o)
    else $error("vdr: accepted trigger not answered after its delay");

  a_no_spurious : assert property (@(posedge clk) disable iff (rst)
    (resp_o && dly_i != '0) |-> (pending_o != '0 && sched_q[0]))
    else $error("vdr: response with nothing pending");

  a_ovf_sticky : assert property (@(posedge clk) disable iff (rst)
    overflow_o |=> overflow_o)
    else $error("vdr: overflow flag fell without reset");

endmodule
`endif

// File: rtl/vdr_fifo.sv
// Pointer-based synchronous FIFO of due timestamps; push and pop may share an edge.
module vdr_fifo
  import vdr_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  ts_t           data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output ts_t           head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ts_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  always_comb begin
    do_pop_s  = pop_i && (cnt_q != '0);
    do_push_s = push_i && ((cnt_q != CW'(DEPTH)) || do_pop_s);
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (do_push_s) begin
      wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/variable_delay_responder.sv
// Trigger->response generator with runtime-programmable delay and bounded outstanding triggers.
// Define VDR_SVA_EN to bind in the embedded concurrent checks.
module variable_delay_responder
  import vdr_pkg::*;
#(
  parameter int MAX_DELAY     = MAX_DELAY_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int DEFAULT_DELAY = DEFAULT_DELAY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_i,
  input  logic [DLY_W-1:0] delay_i,
  input  logic             delay_load,
  output logic             resp_o,
  output logic             busy_o,
  output logic [CW-1:0]    pending_o,
  output logic             load_err_o,
  output logic             overflow_o
);

  ts_t           now_q, now_d, head_s, due_ts_s;
  delay_t        dly_q, dly_d;
  logic          load_err_q, load_err_d, ovf_q, ovf_d;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          zero_dly_s, due_s, push_s, load_ok_s;

  // Equality-only due matching makes timestamp wrap harmless: the in-flight window is under 2^TS_W.
  always_comb begin
    zero_dly_s = (dly_q == '0);
    due_s      = !fifo_empty_s && (head_s == now_q);
    push_s     = trig_i && !zero_dly_s && (!fifo_full_s || due_s);
    due_ts_s   = now_q + ts_t'(dly_q);
    now_d      = now_q + ts_t'(1);
    load_ok_s  = delay_load && (fifo_count_s == '0) && !trig_i;
    load_err_d = delay_load && !load_ok_s;
    if (load_ok_s) begin
      dly_d = clamp_delay(delay_i, delay_t'(MAX_DELAY));
    end else begin
      dly_d = dly_q;
    end
    if (trig_i && !zero_dly_s && fifo_full_s && !due_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q      <= '0;
      dly_q      <= delay_t'(DEFAULT_DELAY);
      load_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      now_q      <= now_d;
      dly_q      <= dly_d;
      load_err_q <= load_err_d;
      ovf_q      <= ovf_d;
    end
  end

  vdr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (due_s),
    .data_i  (due_ts_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s),
    .head_o  (head_s)
  );

  // Zero delay bypasses the FIFO, which is guaranteed empty because loads require idle.
  assign resp_o     = zero_dly_s ? trig_i : due_s;
  assign busy_o     = (fifo_count_s != '0);
  assign pending_o  = fifo_count_s;
  assign load_err_o = load_err_q;
  assign overflow_o = ovf_q;

`ifdef VDR_SVA_EN
  vdr_checker u_chk (
    .clk        (clk),
    .rst        (rst),
    .trig_i     (trig_i),
    .push_i     (push_s),
    .dly_i      (dly_q),
    .resp_o     (resp_o),
    .pending_o  (fifo_count_s),
    .overflow_o (ovf_q)
  );
`endif

endmodule

// File: tb/tb_variable_delay_responder.sv
// Directed bench: a DEPTH=16 responder for the main scenarios and a DEPTH=4 one for overflow.
module tb_variable_delay_responder;
  import vdr_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             trig, dload, trig4, load4;
  logic [DLY_W-1:0] dly, dly4;
  logic             resp, busy, lerr, ovf;
  logic             resp4, busy4, lerr4, ovf4;
  logic [CW-1:0]    pend, pend4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  variable_delay_responder dut (
    .clk(clk), .rst(rst), .trig_i(trig), .delay_i(dly), .delay_load(dload),
    .resp_o(resp), .busy_o(busy), .pending_o(pend), .load_err_o(lerr), .overflow_o(ovf)
  );

  variable_delay_responder #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .trig_i(trig4), .delay_i(dly4), .delay_load(load4),
    .resp_o(resp4), .busy_o(busy4), .pending_o(pend4), .load_err_o(lerr4), .overflow_o(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int maxp;
    int rcount;
    logic h1, h2, t;
    logic [4:0] pat;
    rst = 1'b1; trig = 1'b0; dload = 1'b0; dly = '0;
    trig4 = 1'b0; load4 = 1'b0; dly4 = '0;
    repeat (2) @(posedge clk);

    // 1: default delay of 2
    @(negedge clk); rst = 1'b0; trig = 1'b1; #1;
    chk("rst_resp", resp, 0); chk("rst_busy", busy, 0); chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0); chk("rst_lerr", lerr, 0);
    @(negedge clk); trig = 1'b0; #1;
    chk("t1_resp_e2", resp, 0); chk("t1_busy_e2", busy, 1); chk("t1_pend_e2", pend, 1);
    @(negedge clk); #1;
    chk("t1_resp_e3", resp, 1);
    @(negedge clk); #1;
    chk("t1_resp_e4", resp, 0); chk("t1_busy_e4", busy, 0);

    // 2: D=5, eight back-to-back triggers
    @(negedge clk); dload = 1'b1; dly = 5'd5; #1;
    maxp = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); dload = 1'b0; trig = (k < 8); #1;
      chk("t2_resp", resp, (k >= 5 && k <= 12));
      chk("t2_pend", pend, ((k < 8) ? k : 8) - ((k > 5) ? k - 5 : 0));
      chk("t2_lerr", lerr, 0);
      if (int'(pend) > maxp) maxp = int'(pend);
    end
    chk("t2_peak", maxp, 5);

    // 3: D=0 bypass
    @(negedge clk); trig = 1'b0; dload = 1'b1; dly = 5'd0; #1;
    chk("t3_idle", busy, 0);
    pat = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); dload = 1'b0; trig = pat[i]; #1;
      chk("t3_mirror", resp, pat[i]);
      chk("t3_busy", busy, 0);
    end

    // 5: rejected load while busy, then clamped load
    @(negedge clk); trig = 1'b0; dload = 1'b1; dly = 5'd3; #1;
    @(negedge clk); dload = 1'b0; trig = 1'b1; #1;
    chk("t5_no_bypass", resp, 0);
    @(negedge clk); trig = 1'b0; dload = 1'b1; dly = 5'd7; #1;
    chk("t5_busy", busy, 1);
    @(negedge clk); dload = 1'b0; #1;
    chk("t5_lerr_hi", lerr, 1); chk("t5_resp_early", resp, 0);
    @(negedge clk); #1;
    chk("t5_lerr_lo", lerr, 0); chk("t5_old_d", resp, 1);
    @(negedge clk); #1;
    chk("t5_idle", busy, 0);
    @(negedge clk); dload = 1'b1; dly = 5'd20; #1;
    @(negedge clk); dload = 1'b0; trig = 1'b1; #1;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk); trig = 1'b0; #1;
      chk("t5_clamp", resp, (j == 15));
    end
    chk("t5_lerr_clamp", lerr, 0);

    // 4: DEPTH=4, D=15, six triggers
    @(negedge clk); load4 = 1'b1; dly4 = 5'd15; #1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk); load4 = 1'b0; trig4 = (k < 6); #1;
      chk("t4_resp", resp4, (k >= 15 && k <= 18));
      chk("t4_pend", pend4, ((k < 4) ? k : 4) - ((k > 15) ? ((k - 15 < 4) ? k - 15 : 4) : 0));
      chk("t4_ovf", ovf4, (k >= 5));
    end

    // 6: reset discards pending responses; delay back to 2
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); trig = 1'b1; #1;
    end
    @(negedge clk); trig = 1'b0; #1;
    chk("t6_pend3", pend, 3);
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_pend0", pend, 0); chk("t6_busy0", busy, 0);
    chk("t6_ovf4_clr", ovf4, 0); chk("t6_resp0", resp, 0);
    rcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (resp === 1'b1) rcount++;
    end
    chk("t6_no_resp", rcount, 0);
    @(negedge clk); trig = 1'b1; #1;
    chk("t6_trig_e0", resp, 0);
    @(negedge clk); trig = 1'b0; #1;
    chk("t6_trig_e1", resp, 0);
    @(negedge clk); #1;
    chk("t6_default_d", resp, 1);

    // random triggers at D=2 across timestamp wrap
    h1 = 1'b0; h2 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); t = 1'($urandom_range(0, 1)); trig = t; #1;
      chk("rnd_resp", resp, h2);
      chk("rnd_pend", pend, 32'(h1) + 32'(h2));
      h2 = h1; h1 = t;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
